imm_gen_stage: RTL and testbench

Parametrised, pipelined successor to the combinational immediate extender. It sits between decode and the ALU operand mux. It accepts an instruction word and an immediate-format selector on a valid/ready handshake. It returns the XLEN-wide extended immediate one cycle later through a 2-entry skid buffer, so decode stalls never drop or duplicate an immediate. It also flags illegal selectors and counts them.

---
 rtl/imm_pkg.sv | 45 ++++
 rtl/skid_buf.sv | 67 ++++++
 rtl/imm_gen_stage.sv | 77 +++++++
 tb/tb_imm_gen_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Immediate formats and the shared extend function
// used by the immediate-generation pipeline stage.
package imm_pkg;

    typedef enum logic [3:0] {
        IMM_ZERO   = 4'd0,
        IMM_I_ZEXT = 4'd1,
        IMM_I_SEXT = 4'd2,
        IMM_S      = 4'd3,
        IMM_B      = 4'd4,
        IMM_U      = 4'd5,
        IMM_J      = 4'd6,
        IMM_ZIMM   = 4'd7,
        IMM_SHAMT  = 4'd8
    } imm_sel_e;

    // Returns {illegal, imm[63:0]}; callers keep the low XLEN bits.
    function automatic logic [64:0] imm_extend(
        input logic [31:0] instr,
        input imm_sel_e    sel,
        input int          xlen
    );
        logic [63:0] imm;
        logic        ill;
        imm = '0;
        ill = 1'b0;
        case (sel)
            IMM_ZERO:   imm = '0;
            IMM_I_ZEXT: imm = {52'b0, instr[31:20]};
            IMM_I_SEXT: imm = {{52{instr[31]}}, instr[31:20]};
            IMM_S:      imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:      imm = {{51{instr[31]}}, instr[31], instr[7],
                               instr[30:25], instr[11:8], 1'b0};
            IMM_U:      imm = {{32{instr[31]}}, instr[31:12], 12'b0};
            IMM_J:      imm = {{43{instr[31]}}, instr[31], instr[19:12],
                               instr[20], instr[30:21], 1'b0};
            IMM_ZIMM:   imm = {59'b0, instr[19:15]};
            IMM_SHAMT:  imm = (xlen == 64) ? {58'b0, instr[25:20]}
                                           : {59'b0, instr[24:20]};
            default:    ill = 1'b1;
        endcase
        return {ill, imm};
    endfunction

endpackage

// File: rtl/skid_buf.sv
// Generic 2-entry valid/ready skid buffer. in_ready is
// purely registered so no combinational path from out_ready.
module skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         m_valid_q, m_valid_d;
    logic         k_valid_q, k_valid_d;
    logic [W-1:0] m_data_q, m_data_d;
    logic [W-1:0] k_data_q, k_data_d;
    logic         acc;
    logic         m_free;

    assign in_ready  = !k_valid_q;
    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;
    assign acc       = in_valid && !k_valid_q;
    assign m_free    = !m_valid_q || out_ready;

    // Refill M from K first, else from input; overflow into K.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        k_valid_d = k_valid_q;
        k_data_d  = k_data_q;
        if (m_free) begin
            if (k_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = k_data_q;
                k_valid_d = 1'b0;
            end else if (acc) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (acc) begin
            k_valid_d = 1'b1;
            k_data_d  = in_data;
        end
    end

    // Main and skid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            k_valid_q <= 1'b0;
            m_data_q  <= '0;
            k_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            k_valid_q <= k_valid_d;
            m_data_q  <= m_data_d;
            k_data_q  <= k_data_d;
        end
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Pipelined immediate generator: extend, count illegal
// selectors, and register the result through a skid buffer.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [3:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int W = XLEN + TAG_W + 1;

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end

    logic [64:0]      ext;
    logic [W-1:0]     in_data;
    logic [W-1:0]     out_data;
    logic             acc;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unused_ext;

    assign ext        = imm_extend(in_instr, imm_sel_e'(in_sel), XLEN);
    assign unused_ext = ^ext;
    assign in_data    = {ext[64], in_tag, ext[XLEN-1:0]};
    assign acc        = in_valid && in_ready;

    // Saturating count of accepted illegal selectors.
    always_comb begin
        cnt_d = cnt_q;
        if (acc && ext[64] && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign illegal_cnt = cnt_q;

    skid_buf #(
        .W(W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    assign {out_illegal, out_tag, out_imm} = out_data;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed and soak bench for imm_gen_stage, with a
// 32-bit/CNT_W=4 instance and a 64-bit instance on shared inputs.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [3:0]  in_sel;
    logic [7:0]  in_tag;

    logic        a_in_ready, a_out_valid, a_out_ill;
    logic [31:0] a_out_imm;
    logic [7:0]  a_out_tag;
    logic [3:0]  a_cnt;

    logic        b_in_ready, b_out_valid, b_out_ill;
    logic [63:0] b_out_imm;
    logic [7:0]  b_out_tag;
    logic [15:0] b_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .TAG_W(8), .CNT_W(4)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_imm(a_out_imm), .out_tag(a_out_tag),
        .out_illegal(a_out_ill), .illegal_cnt(a_cnt)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(8), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_imm(b_out_imm), .out_tag(b_out_tag),
        .out_illegal(b_out_ill), .illegal_cnt(b_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic one(input string nm, input logic [31:0] ins,
                       input logic [3:0] sel, input logic [7:0] tg,
                       input logic [31:0] e32, input logic [63:0] e64,
                       input logic ill);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = ins;
        in_sel   = sel;
        in_tag   = tg;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({nm, "_va"}, 64'(a_out_valid), 64'd1);
        chk({nm, "_vb"}, 64'(b_out_valid), 64'd1);
        chk({nm, "_ia"}, 64'(a_out_imm), 64'(e32));
        chk({nm, "_ib"}, b_out_imm, e64);
        chk({nm, "_ta"}, 64'(a_out_tag), 64'(tg));
        chk({nm, "_la"}, 64'(a_out_ill), 64'(ill));
        chk({nm, "_lb"}, 64'(b_out_ill), 64'(ill));
    endtask

    initial begin
        logic [7:0] got[$];
        int         exp_q[$];
        int         sent, rcvd, cyc, e;
        logic       acc, stalled;
        logic [7:0] hold_tag;

        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_instr  = '0;
        in_sel    = '0;
        in_tag    = '0;
        rst_n     = 1'b0;

        #12;
        chk("rst_va", 64'(a_out_valid), 64'd0);
        chk("rst_ia", 64'(a_out_imm), 64'd0);
        chk("rst_ib", b_out_imm, 64'd0);
        chk("rst_ta", 64'(a_out_tag), 64'd0);
        chk("rst_la", 64'(a_out_ill), 64'd0);
        chk("rst_ca", 64'(a_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_rdy", 64'(a_in_ready), 64'd1);

        one("isext", 32'hFFF00093, 4'd2, 8'h11,
            32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        one("izext", 32'hFFF00093, 4'd1, 8'h12,
            32'h00000FFF, 64'h0000000000000FFF, 1'b0);
        one("b", 32'hFE000EE3, 4'd4, 8'h13,
            32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        one("u", 32'h123450B7, 4'd5, 8'h14,
            32'h12345000, 64'h0000000012345000, 1'b0);
        one("uneg", 32'h800000B7, 4'd5, 8'h15,
            32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        one("shamt", 32'h03F01013, 4'd8, 8'h16,
            32'h0000001F, 64'h000000000000003F, 1'b0);
        one("s", 32'hFE000FA3, 4'd3, 8'h17,
            32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        one("j", 32'hFFDFF06F, 4'd6, 8'h18,
            32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        one("zimm", 32'h000F8000, 4'd7, 8'h19,
            32'h0000001F, 64'h000000000000001F, 1'b0);
        one("zero", 32'hFFFFFFFF, 4'd0, 8'h1A,
            32'h0, 64'h0, 1'b0);
        one("ill", 32'hFFFFFFFF, 4'd12, 8'h1B,
            32'h0, 64'h0, 1'b1);
        chk("ill_ca", 64'(a_cnt), 64'd1);
        chk("ill_cb", 64'(b_cnt), 64'd1);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sel   = 4'(9 + (i % 7));
            in_tag   = 8'(i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("sat_ca", 64'(a_cnt), 64'hF);
        chk("sat_cb", 64'(b_cnt), 64'd21);

        // backpressure: tags 1,2,3 with out_ready low
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100000;
        in_sel    = 4'd1;
        in_tag    = 8'd1;
        @(negedge clk);
        in_tag = 8'd2;
        @(negedge clk);
        in_tag = 8'd3;
        #1;
        chk("bp_rdy0", 64'(a_in_ready), 64'd0);
        chk("bp_tag1", 64'(a_out_tag), 64'd1);
        @(negedge clk);
        #1;
        chk("bp_rdy1", 64'(a_in_ready), 64'd0);
        chk("bp_hold", 64'({a_out_valid, a_out_tag}), 64'h101);
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (a_out_valid) got.push_back(a_out_tag);
            acc = in_valid && a_in_ready;
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
            @(negedge clk);
        end
        chk("bp_n", 64'(got.size()), 64'd3);
        while (got.size() < 3) got.push_back(8'hFF);
        chk("bp_o0", 64'(got[0]), 64'd1);
        chk("bp_o1", 64'(got[1]), 64'd2);
        chk("bp_o2", 64'(got[2]), 64'd3);
        chk("bp_rdy", 64'(a_in_ready), 64'd1);

        // reset while M and K are both full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 4'd12;
        in_tag    = 8'd9;
        @(negedge clk);
        in_tag = 8'd10;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("rk_full", 64'(a_in_ready), 64'd0);
        chk("rk_cnt", 64'(b_cnt), 64'd23);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_va", 64'(a_out_valid), 64'd0);
        chk("ar_vb", 64'(b_out_valid), 64'd0);
        chk("ar_ca", 64'(a_cnt), 64'd0);
        chk("ar_cb", 64'(b_cnt), 64'd0);
        chk("ar_ta", 64'(a_out_tag), 64'd0);
        chk("ar_la", 64'(a_out_ill), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk("ar_stale", 64'(a_out_valid), 64'd0);
            chk("ar_rdy", 64'(a_in_ready), 64'd1);
        end

        // random valid/ready soak with a FIFO scoreboard
        sent    = 0;
        rcvd    = 0;
        cyc     = 0;
        stalled = 1'b0;
        hold_tag = '0;
        in_sel  = 4'd1;
        while (rcvd < 10000 && cyc < 60000) begin
            @(negedge clk);
            if (!in_valid && sent < 10000 && $urandom_range(3) != 0) begin
                in_valid = 1'b1;
                in_instr = {sent[11:0], 20'h0};
                in_tag   = sent[7:0];
            end
            out_ready = ($urandom_range(3) != 0);
            #1;
            if (stalled) begin
                chk("sk_hold", 64'({a_out_valid, a_out_tag}),
                    64'({1'b1, hold_tag}));
            end
            if (a_out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sk_spur", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sk_tag", 64'(a_out_tag), 64'(e[7:0]));
                    chk("sk_ia", 64'(a_out_imm), {52'b0, e[11:0]});
                    chk("sk_ib", b_out_imm, {52'b0, e[11:0]});
                end
                rcvd++;
            end
            stalled  = a_out_valid && !out_ready;
            hold_tag = a_out_tag;
            acc = in_valid && a_in_ready;
            if (acc) begin
                exp_q.push_back(sent);
                sent++;
            end
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
            cyc++;
        end
        chk("sk_count", 64'(rcvd), 64'd10000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
